pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage MINAv2 pipeline (IA, IF/ID, ID/EX, EX/MEM, MEM/WB). It merges the load-use hazard flag from the hazard detection unit, taken-branch redirects from EX, and the handshakes of multi-cycle instruction and data memories into one consistent set of per-register stall and flush controls. It also tracks halt and bus-timeout conditions and keeps a saturating stall-cycle performance counter.

## Interface
- `MEM_TIMEOUT`, default 255: maximum data-memory wait cycles before a bus error; must be ≥ 1.
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk` in 1: clock. The block has one clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `load_hazard` in 1: load-use hazard between the ID sources and the ID/EX destination.
- `branch_taken` in 1: the instruction in EX redirects the PC this cycle.
- `imem_ack` in 1: instruction fetch data is valid this cycle.
- `dmem_req` in 1: MEM stage holds a load or store.
- `dmem_ack` in 1: data memory completes the MEM access this cycle.
- `halt_req` in 1: a halt instruction is in MEM this cycle.
- `stall_ia` out 1: hold the PC and IA.
- `stall_if_id` out 1: hold IF/ID.
- `stall_id_ex` out 1: hold ID/EX.
- `stall_ex_mem` out 1: hold EX/MEM.
- `bubble_mem_wb` out 1: load a NOP into MEM/WB.
- `flush_if_id` out 1: load a NOP into IF/ID.
- `flush_id_ex` out 1: load a NOP into ID/EX.
- `halted` out 1: the core is halted.
- `bus_error` out 1: sticky flag for a data-memory timeout.
- `stall_cycles` out `CNT_W`: saturating count of stalled cycles.

## Operation
- States: `RUN`, `MEM_WAIT`, `HALTED`.
- All stall, flush and bubble outputs are combinational from the current state and inputs. State, timer and counter are registered.

**Memory wait (highest priority)**
- Trigger: in `RUN`, `dmem_req && !dmem_ack`. The same cycle asserts `stall_ia`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem` and `bubble_mem_wb`, and the next state is `MEM_WAIT`.
- In `MEM_WAIT` the same outputs stay asserted.
- `dmem_ack` returns the block to `RUN`. The ack cycle has no memory stall, and the other rules apply normally.
- No flush occurs during a memory wait. A pending `branch_taken` stays asserted because EX is frozen, and it takes effect after the wait ends.

**Branch (RUN, no memory wait)**
- `branch_taken` asserts `flush_if_id` and `flush_id_ex`.
- It overrides `load_hazard`, so `stall_ia` and `stall_if_id` stay low, and it overrides the IMEM rule.

**Load hazard (RUN, no memory wait, no branch)**
- Asserts `stall_ia`, `stall_if_id` and `flush_id_ex`.

**IMEM wait (RUN, none of the above)**
- `!imem_ack` asserts `stall_ia` and `flush_if_id`; downstream stages advance.
- If `load_hazard` and `!imem_ack` occur together, the load-hazard outputs apply and `flush_if_id` stays low.

**Halt**
- In `RUN`, `halt_req` with no memory stall that cycle moves the block to `HALTED` next cycle.
- `HALTED` asserts every stall output plus `halted`. It is left only by `rst`.

**Timeout**
- A wait timer clears on entry to `MEM_WAIT` and increments each cycle in `MEM_WAIT`.
- If the timer reaches `MEM_TIMEOUT` without `dmem_ack`, `bus_error` sets and the next state is `HALTED`.
- If `dmem_ack` arrives in the same cycle the timer reaches `MEM_TIMEOUT`, the ack wins and `bus_error` stays low.

**Counter**
- `stall_cycles` increments in every non-`HALTED` cycle in which `stall_ia` is 1.
- It saturates at all-ones.

## Timing
- Reset values: state `RUN`, timer 0, `stall_cycles` 0, `halted` 0, `bus_error` 0.
- With `rst` high, all combinational outputs are forced to 0, and `rst` overrides every other input.
- Stall and flush outputs have zero-cycle latency from their inputs.
- `halted` rises one cycle after the accepting `halt_req`.
- Counter value is visible the cycle after the stalled cycle.
- A load-use hazard costs exactly one bubble cycle, because `load_hazard` drops once ID/EX holds the NOP.
- Reset in the middle of `MEM_WAIT` or `HALTED` returns to `RUN` on the next edge and does not set `bus_error`.

## Structure
- The package `types` gets `ctrl_state_e` (`RUN`, `MEM_WAIT`, `HALTED`, 2-bit encoding).
- It also gets a `pipe_ctrl_t` struct bundling the seven stall/flush/bubble bits, so stages consume one bundle.
- Natural sub-module: `sat_counter` (parameterised width, `inc` input, saturating). It is used for both `stall_cycles` and the wait timer.

## Test plan
- **Load-use:** `load_hazard` = 1 for one cycle in `RUN` → `stall_ia` = `stall_if_id` = `flush_id_ex` = 1, other outputs 0; `stall_cycles` goes 0 → 1.
- **Branch beats load:** `branch_taken` = `load_hazard` = 1 → `flush_if_id` = `flush_id_ex` = 1, `stall_ia` = 0.
- **Data-memory wait:** `dmem_req` = 1 with `dmem_ack` low for 3 cycles, then high → the four stall outputs and `bubble_mem_wb` are high for 3 cycles, all low on the ack cycle, state is `RUN` after.
- **Timeout:** `MEM_TIMEOUT` = 4, `dmem_req` held with no ack → `bus_error` and `halted` are 1 after the timeout cycle, and all stall outputs stay high until `rst`.
- **Halt:** `halt_req` pulse in `RUN` → `halted` = 1 next cycle; later `rst` high for one cycle → `halted` = 0, `stall_cycles` = 0.
- **Saturation:** `CNT_W` = 4 with `load_hazard` held for 20 cycles → `stall_cycles` stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the MINAv2 pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } ctrl_state_e;

  // One bundle of per-register hold/kill controls consumed by the stages.
  typedef struct packed {
    logic stall_ia;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic bubble_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_IDLE = '0;

  // Wait timer width: must hold values up to the timeout limit.
  function automatic int unsigned timer_width(input int unsigned limit);
    if (limit < 1) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/handshake inputs and stall/flush controls of the pipeline sequencer.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_hazard;
  logic             branch_taken;
  logic             imem_ack;
  logic             dmem_req;
  logic             dmem_ack;
  logic             halt_req;
  logic             stall_ia;
  logic             stall_if_id;
  logic             stall_id_ex;
  logic             stall_ex_mem;
  logic             bubble_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             halted;
  logic             bus_error;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output load_hazard, branch_taken, imem_ack, dmem_req, dmem_ack, halt_req,
    input  stall_ia, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb,
           flush_if_id, flush_id_ex, halted, bus_error, stall_cycles
  );

  modport slave (
    input  load_hazard, branch_taken, imem_ack, dmem_req, dmem_ack, halt_req,
    output stall_ia, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb,
           flush_if_id, flush_id_ex, halted, bus_error, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, branch, IMEM/DMEM handshakes, halt
// and data-bus timeout into one set of per-register pipeline controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
);

  localparam int unsigned TIMER_W = timer_width(MEM_TIMEOUT);

  ctrl_state_e        state;
  ctrl_state_e        state_nxt;
  pipe_ctrl_t         ctrl;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   cnt;
  logic               mem_stall;
  logic               timeout;
  logic               timer_clr;
  logic               timer_inc;
  logic               cnt_inc;
  logic               halted_q;
  logic               bus_error_q;

  // An outstanding data access freezes everything up to EX/MEM until acked.
  assign mem_stall = !bus.dmem_ack &&
                     (((state == RUN) && bus.dmem_req) || (state == MEM_WAIT));
  // Last permitted wait cycle passing without an ack.
  assign timeout   = (state == MEM_WAIT) && !bus.dmem_ack &&
                     (timer == TIMER_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_stall)         state_nxt = MEM_WAIT;
        else if (bus.halt_req) state_nxt = HALTED;
      end
      MEM_WAIT: begin
        if (timeout)           state_nxt = HALTED;
        else if (bus.dmem_ack) state_nxt = bus.halt_req ? HALTED : RUN;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // Priority: halted > memory wait > branch > load-use > fetch wait.
  always_comb begin
    ctrl = PIPE_IDLE;
    if (!rst) begin
      if (state == HALTED) begin
        ctrl.stall_ia     = 1'b1;
        ctrl.stall_if_id  = 1'b1;
        ctrl.stall_id_ex  = 1'b1;
        ctrl.stall_ex_mem = 1'b1;
      end else if (mem_stall) begin
        ctrl.stall_ia      = 1'b1;
        ctrl.stall_if_id   = 1'b1;
        ctrl.stall_id_ex   = 1'b1;
        ctrl.stall_ex_mem  = 1'b1;
        ctrl.bubble_mem_wb = 1'b1;
      end else if (bus.branch_taken) begin
        ctrl.flush_if_id = 1'b1;
        ctrl.flush_id_ex = 1'b1;
      end else if (bus.load_hazard) begin
        ctrl.stall_ia    = 1'b1;
        ctrl.stall_if_id = 1'b1;
        ctrl.flush_id_ex = 1'b1;
      end else if (!bus.imem_ack) begin
        ctrl.stall_ia    = 1'b1;
        ctrl.flush_if_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      halted_q <= (state_nxt == HALTED);
      if (timeout) bus_error_q <= 1'b1;
    end
  end

  assign timer_clr = (state == RUN) && (state_nxt == MEM_WAIT);
  assign timer_inc = (state == MEM_WAIT);
  assign cnt_inc   = ctrl.stall_ia && (state != HALTED);

  sat_counter #(.W(TIMER_W)) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .inc (timer_inc),
    .q   (timer)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (cnt_inc),
    .q   (cnt)
  );

  assign bus.stall_ia      = ctrl.stall_ia;
  assign bus.stall_if_id   = ctrl.stall_if_id;
  assign bus.stall_id_ex   = ctrl.stall_id_ex;
  assign bus.stall_ex_mem  = ctrl.stall_ex_mem;
  assign bus.bubble_mem_wb = ctrl.bubble_mem_wb;
  assign bus.flush_if_id   = ctrl.flush_if_id;
  assign bus.flush_id_ex   = ctrl.flush_id_ex;
  assign bus.halted        = halted_q;
  assign bus.bus_error     = bus_error_q;
  assign bus.stall_cycles  = cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios then random traffic.
module tb_pipeline_ctrl;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct {
    logic [6:0] ctrl;
    logic       halted;
    logic       bus_error;
    int         cnt;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model of the sequencer's architectural state.
  bit m_halted  = 1'b0;
  bit m_bus_err = 1'b0;
  bit m_waiting = 1'b0;
  int m_wait    = 0;
  int m_cnt     = 0;

  initial begin
    bus.load_hazard  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.imem_ack     = 1'b1;
    bus.dmem_req     = 1'b0;
    bus.dmem_ack     = 1'b0;
    bus.halt_req     = 1'b0;
  end

  task automatic step(input string tag, input bit r, input bit lh, input bit bt,
                      input bit ia, input bit dreq, input bit dack, input bit hr);
    exp_t e;
    bit s_ia, s_ifid, s_idex, s_exmem, bub, f_ifid, f_idex, stalled;
    @(posedge clk);
    #1;
    rst = r; bus.load_hazard = lh; bus.branch_taken = bt; bus.imem_ack = ia;
    bus.dmem_req = dreq; bus.dmem_ack = dack; bus.halt_req = hr;
    e.halted = m_halted; e.bus_error = m_bus_err; e.cnt = m_cnt; e.tag = tag;
    {s_ia, s_ifid, s_idex, s_exmem, bub, f_ifid, f_idex} = '0;
    if (r) begin
      m_halted = 0; m_bus_err = 0; m_waiting = 0; m_wait = 0; m_cnt = 0;
    end else if (m_halted) begin
      {s_ia, s_ifid, s_idex, s_exmem} = 4'b1111;
    end else begin
      stalled = m_waiting ? !dack : (dreq && !dack);
      if (stalled) begin
        {s_ia, s_ifid, s_idex, s_exmem, bub} = 5'b11111;
        if (m_waiting) begin
          m_wait = m_wait + 1;
          if (m_wait == int'(MEM_TIMEOUT)) begin
            m_bus_err = 1; m_halted = 1; m_waiting = 0;
          end
        end else begin
          m_waiting = 1; m_wait = 0;
        end
      end else begin
        m_waiting = 0;
        if (bt)       begin f_ifid = 1; f_idex = 1; end
        else if (lh)  begin s_ia = 1; s_ifid = 1; f_idex = 1; end
        else if (!ia) begin s_ia = 1; f_ifid = 1; end
        if (hr) m_halted = 1;
      end
      if (s_ia) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    e.ctrl = {s_ia, s_ifid, s_idex, s_exmem, bub, f_ifid, f_idex};
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Monitor: every cycle is an output beat; compare against the oldest expectation.
  initial begin
    exp_t e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {bus.stall_ia, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
               bus.bubble_mem_wb, bus.flush_if_id, bus.flush_id_ex};
        n_checks++;
        if (got === e.ctrl) n_pass++;
        else $display("FAIL %s ctrl got=%b exp=%b t=%0t", e.tag, got, e.ctrl, $time);
        n_checks++;
        if (bus.halted === e.halted) n_pass++;
        else $display("FAIL %s halted got=%b exp=%b t=%0t", e.tag, bus.halted, e.halted, $time);
        n_checks++;
        if (bus.bus_error === e.bus_error) n_pass++;
        else $display("FAIL %s bus_error got=%b exp=%b t=%0t", e.tag, bus.bus_error, e.bus_error, $time);
        n_checks++;
        if (!$isunknown(bus.stall_cycles) && int'(bus.stall_cycles) == e.cnt) n_pass++;
        else $display("FAIL %s stall_cycles got=%0d exp=%0d t=%0t", e.tag, bus.stall_cycles, e.cnt, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, lh, bt, ia, dreq, dack, hr;
    step("reset", 1, 0, 0, 1, 0, 0, 0);
    step("reset", 1, 0, 0, 1, 0, 0, 0);
    idle("idle", 2);

    step("load_use", 0, 1, 0, 1, 0, 0, 0);
    idle("after_load", 1);
    step("br_beats_load", 0, 1, 1, 1, 0, 0, 0);
    step("br_beats_imem", 0, 0, 1, 0, 0, 0, 0);
    step("imem_wait", 0, 0, 0, 0, 0, 0, 0);
    step("load_and_imem", 0, 1, 0, 0, 0, 0, 0);
    idle("idle", 1);

    repeat (3) step("dmem_wait", 0, 0, 0, 1, 1, 0, 0);
    step("dmem_ack", 0, 0, 0, 1, 1, 1, 0);
    idle("after_ack", 1);

    repeat (2) step("wait_pending_br", 0, 0, 1, 1, 1, 0, 0);
    step("ack_then_br", 0, 0, 1, 1, 1, 1, 0);
    idle("idle", 1);

    repeat (MEM_TIMEOUT) step("wait_to_limit", 0, 0, 0, 1, 1, 0, 0);
    step("ack_at_limit", 0, 0, 0, 1, 1, 1, 0);
    idle("after_limit_ack", 2);

    repeat (MEM_TIMEOUT + 1) step("timeout_wait", 0, 0, 0, 1, 1, 0, 0);
    step("timeout_halted", 0, 1, 1, 0, 1, 1, 0);
    step("timeout_halted", 0, 0, 0, 1, 0, 0, 0);
    step("timeout_halted", 0, 1, 0, 1, 0, 0, 1);
    step("reset_from_halt", 1, 0, 0, 1, 0, 0, 0);
    idle("after_reset", 1);

    step("halt_pulse", 0, 0, 0, 1, 0, 0, 1);
    idle("halted", 3);
    step("reset_halt", 1, 0, 0, 1, 0, 0, 0);
    idle("after_reset", 2);

    repeat (3) step("wait_before_rst", 0, 0, 0, 1, 1, 0, 0);
    step("reset_in_wait", 1, 0, 0, 1, 1, 0, 0);
    idle("after_wait_rst", 6);

    repeat (20) step("saturate", 0, 1, 0, 1, 0, 0, 0);
    idle("saturated", 2);
    step("reset", 1, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 29) == 0) || (m_halted && ($urandom_range(0, 3) == 0));
      lh   = ($urandom_range(0, 3) == 0);
      bt   = ($urandom_range(0, 4) == 0);
      ia   = ($urandom_range(0, 3) != 0);
      dreq = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
      dack = ($urandom_range(0, 2) == 0);
      hr   = ($urandom_range(0, 39) == 0);
      step("random", r, lh, bt, ia, dreq, dack, hr);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
